// File: rtl/vga_timing_pkg.sv
// Shared timing defaults and FSM state type for the VGA pixel output path.
// Holds the 640x480@60 constants, derived totals and a counter-width helper.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL =
    DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL =
    DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } state_e;

  function automatic int cnt_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Free-running h/v raster counters with active, sync and frame-boundary decode.
// Ports: clk_i, rst_i (async high); active_o, hsync_n_o, vsync_n_o, fb_o.
module vga_timing_counter
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic active_o,
  output logic hsync_n_o,
  output logic vsync_n_o,
  output logic fb_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = cnt_width(H_TOTAL);
  localparam int VW = cnt_width(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_wrap;
  int            h_pos, v_pos;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Decode in int so sync-end bounds equal to the total never overflow.
  always_comb begin
    h_pos     = int'(h_cnt_q);
    v_pos     = int'(v_cnt_q);
    active_o  = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
    hsync_n_o = !((h_pos >= H_ACTIVE + H_FP) &&
                  (h_pos <  H_ACTIVE + H_FP + H_SYNC));
    vsync_n_o = !((v_pos >= V_ACTIVE + V_FP) &&
                  (v_pos <  V_ACTIVE + V_FP + V_SYNC));
    fb_o      = (h_pos == 0) && (v_pos == V_ACTIVE + V_FP);
  end

endmodule

// File: rtl/vga_pixel_out.sv
// VGA pixel output: frame-locked FSM, FIFO pop logic and registered RGB565/syncs.
// Ports: iCLOCK/iRESET, iENA, FIFO head/empty/pop, frame-start, VGA outs, underflow.
module vga_pixel_out
  import vga_timing_pkg::*;
#(
  parameter int N        = 16,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic         iCLOCK,
  input  logic         iRESET,
  input  logic         iENA,
  input  logic         iFIFO_EMPTY,
  input  logic [N-1:0] iFIFO_DATA,
  input  logic         iUNDERFLOW_CLR,
  output logic         oFIFO_RD_EN,
  output logic         oFRAME_START,
  output logic [4:0]   oVGA_R,
  output logic [5:0]   oVGA_G,
  output logic [4:0]   oVGA_B,
  output logic         oVGA_HSYNC,
  output logic         oVGA_VSYNC,
  output logic         oVGA_DE,
  output logic         oUNDERFLOW
);

  logic   active, hsync_n, vsync_n, fb;
  state_e state_q, state_d;
  logic   pop, starve;
  logic [4:0] r_q, r_d;
  logic [5:0] g_q, g_d;
  logic [4:0] b_q, b_d;
  logic   hs_q, vs_q, de_q;
  logic   uf_q, uf_d;

  vga_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_i     (iCLOCK),
    .rst_i     (iRESET),
    .active_o  (active),
    .hsync_n_o (hsync_n),
    .vsync_n_o (vsync_n),
    .fb_o      (fb)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (iENA) state_d = ARM;
      ARM: begin
        if (!iENA)   state_d = IDLE;
        else if (fb) state_d = RUN;
      end
      RUN: if (fb && !iENA) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // IDLE can only step to ARM, so frame-start never fires from IDLE.
  assign oFRAME_START = fb && (state_d == RUN);

  assign pop    = (state_q == RUN) && active && !iFIFO_EMPTY;
  assign starve = (state_q == RUN) && active &&  iFIFO_EMPTY;
  assign oFIFO_RD_EN = pop;

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (pop) begin
      r_d = iFIFO_DATA[15:11];
      g_d = iFIFO_DATA[10:5];
      b_d = iFIFO_DATA[4:0];
    end
    uf_d = uf_q;
    if (starve)              uf_d = 1'b1;
    else if (iUNDERFLOW_CLR) uf_d = 1'b0;
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state_q <= IDLE;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      de_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      hs_q    <= hsync_n;
      vs_q    <= vsync_n;
      de_q    <= active;
      uf_q    <= uf_d;
    end
  end

  assign oVGA_R     = r_q;
  assign oVGA_G     = g_q;
  assign oVGA_B     = b_q;
  assign oVGA_HSYNC = hs_q;
  assign oVGA_VSYNC = vs_q;
  assign oVGA_DE    = de_q;
  assign oUNDERFLOW = uf_q;

endmodule

// File: doc/vga_pixel_out.md
VGA_PIXEL_OUT -- requirements
Module: vga_pixel_out

Interface
REQ-001 Parameter N, default 16: pixel word width; RGB565 packing R=[15:11], G=[10:5], B=[4:0].
REQ-002 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal timing in clocks.
REQ-003 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical timing in lines.
REQ-004 iCLOCK  in  1  pixel clock; the block's only clock.
REQ-005 iRESET  in  1  asynchronous, active-high reset.
REQ-006 iENA  in  1  display enable; sampled only at frame boundaries.
REQ-007 iFIFO_EMPTY  in  1  upstream sync FIFO empty flag.
REQ-008 iFIFO_DATA  in  N  show-ahead FIFO head word, valid whenever iFIFO_EMPTY=0.
REQ-009 oFIFO_RD_EN  out  1  pops one word in the cycle it is high.
REQ-010 oFRAME_START  out  1  one-cycle pulse telling the upstream fetcher to flush and prefetch the next frame.
REQ-011 oVGA_R/oVGA_G/oVGA_B  out  5/6/5  registered pixel colour.
REQ-012 oVGA_HSYNC, oVGA_VSYNC  out  1 each  registered syncs, active-low.
REQ-013 oVGA_DE  out  1  registered data-enable, high during the visible area.
REQ-014 oUNDERFLOW  out  1  sticky flag: a pixel was needed while the FIFO was empty.
REQ-015 iUNDERFLOW_CLR  in  1  synchronous clear of oUNDERFLOW.

Function
REQ-016 h_cnt counts 0..H_TOTAL-1 (H_TOTAL=sum of H params, 800) and wraps to 0; v_cnt increments at h_cnt wrap and counts 0..V_TOTAL-1 (525), then wraps; both are 10 bits at default parameters.
REQ-017 The active area is h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; HSYNC is low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; VSYNC follows the same rule on v_cnt.
REQ-018 The counters free-run from reset regardless of iENA or state.
REQ-019 The FSM has three states: IDLE (blank, no pops), ARM (enable seen, waiting for boundary), RUN (streaming).
REQ-020 The frame boundary FB is h_cnt==0 and v_cnt==V_ACTIVE+V_FP, i.e. the first VSYNC clock.
REQ-021 FSM transitions: IDLE->ARM when iENA=1; ARM->IDLE when iENA=0 before FB; ARM->RUN at FB; RUN->IDLE at FB if iENA=0; otherwise RUN holds.
REQ-022 oFRAME_START pulses high for exactly the FB cycle when the next state is RUN (ARM->RUN, or RUN staying RUN); it is never asserted in IDLE.
REQ-023 oFIFO_RD_EN = (state==RUN) and active area and !iFIFO_EMPTY; this is combinational and the word is consumed in the same cycle.
REQ-024 In RUN, active area and FIFO non-empty: the colour register loads iFIFO_DATA fields at the next edge, giving 1-clock latency.
REQ-025 In RUN, active area and FIFO empty: output black, do not pop, and set oUNDERFLOW at the next edge. The missing pixel is not replayed, so the frame shifts until the next oFRAME_START flush.
REQ-026 Outside the active area or outside RUN, the colour is 0.
REQ-027 HSYNC, VSYNC and DE are registered from the same cycle's counters, so they align with the colour outputs (all lag the counters by 1 clock).
REQ-028 DE is high in the active area in every state; pixels are black unless in RUN.
REQ-029 If iUNDERFLOW_CLR and a new underflow occur in the same cycle, the set wins.
REQ-030 The block never pops in the FB cycle, because FB lies outside the active area.

Reset
REQ-031 While iRESET=1 (async assert, sync-deassert handled upstream): h_cnt=0, v_cnt=0, state=IDLE, and all colour outputs are 0.
REQ-032 During reset, oVGA_HSYNC=1, oVGA_VSYNC=1, oVGA_DE=0, oUNDERFLOW=0, oFRAME_START=0 and oFIFO_RD_EN=0.
REQ-033 A reset asserted mid-frame takes effect immediately; after release the block restarts from IDLE and pops nothing until a new ARM->RUN.

Structure
REQ-034 A shared package vga_timing_pkg holds the default 640x480 timing constants, derived H_TOTAL/V_TOTAL, and the FSM state enum (IDLE, ARM, RUN).
REQ-035 One sub-module, vga_timing_counter, holds the h/v counters and the active/hsync/vsync/FB decode; vga_pixel_out holds the FSM, the pop logic and the output registers.

Verification
REQ-036 Reset release with iENA=0 for 2 frames: HSYNC low 96 clocks per 800-clock line; VSYNC low 2 lines per 525; DE high 640x480; colour 0; oFIFO_RD_EN never high.
REQ-037 iENA=1 with FIFO always full of 16'hF800: exactly one oFRAME_START at FB; next frame shows R=31, G=0, B=0 on all 307200 DE pixels; 307200 pops per frame.
REQ-038 FIFO drives an incrementing pattern: pixel k on the output is word k, appearing 1 clock after its pop; syncs stay aligned with DE.
REQ-039 FIFO empty for clocks 100..109 of line 5: 10 black pixels, no pops in that window, oUNDERFLOW=1 and held; iUNDERFLOW_CLR clears it; simultaneous clear and underflow leaves it 1.
REQ-040 iENA dropped mid-frame in RUN: streaming continues to FB, then IDLE with no oFRAME_START; a pulse on iENA that ends before FB returns ARM->IDLE with no pop.
REQ-041 iRESET asserted mid-line in RUN: outputs take their reset values asynchronously; after release, counters start at 0 and state is IDLE.
